// File: rtl/cassette_rec.sv
// Cassette recorder: decodes the FSK cassette-in stream into bytes and writes each block to
// SDRAM as leader bytes, 0x3C, then data, so the image replays through the player unchanged.
module cassette_rec #(
    parameter int unsigned THRESH       = 559,
    parameter int unsigned MIN_PER      = 150,
    parameter int unsigned TIMEOUT      = 1500,
    parameter int unsigned LEADER_BYTES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Q,
    input  logic        en,
    input  logic        record,
    input  logic        din,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_wdata,
    output logic        sdram_wr,
    output logic [2:0]  status
);

    localparam logic [10:0] ThreshC   = 11'(THRESH);
    localparam logic [10:0] MinPerC   = 11'(MIN_PER);
    localparam logic [10:0] TimeoutC  = 11'(TIMEOUT);
    localparam logic [7:0]  LeadLastC = 8'(LEADER_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHunt  = 3'd1,
        StLead  = 3'd2,
        StSyncb = 3'd3,
        StData  = 3'd4
    } state_t;

    state_t      state;
    logic        din_s1, din_s2, din_last, q_last, rec_last;
    logic [10:0] cnt, cnt_inc;
    logic [7:0]  shreg, shreg_nx, pend_data, lead_cnt;
    logic        prev_bit, leader_seen, pend_valid;
    logic [4:0]  alt;
    logic [2:0]  bit_cnt;
    logic        tick, meter_on, din_rise, bit_ok, bit_val, lost;

    // cnt_inc is the period as seen on this tick, counting the tick itself.
    always_comb begin
        tick     = Q & ~q_last & en;
        meter_on = (state != StIdle);
        din_rise = din_s2 & ~din_last;
        cnt_inc  = (cnt == TimeoutC) ? cnt : cnt + 11'd1;
        bit_ok   = meter_on & din_rise & (cnt_inc >= MinPerC) & (cnt_inc < TimeoutC);
        bit_val  = (cnt_inc < ThreshC);
        shreg_nx = {bit_val, shreg[7:1]};
        lost     = meter_on & (cnt_inc == TimeoutC) & (cnt != TimeoutC);
    end

    assign status = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            din_s1      <= 1'b0;
            din_s2      <= 1'b0;
            din_last    <= 1'b0;
            q_last      <= 1'b0;
            rec_last    <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
            pend_data   <= '0;
            lead_cnt    <= '0;
            prev_bit    <= 1'b0;
            leader_seen <= 1'b0;
            pend_valid  <= 1'b0;
            alt         <= '0;
            bit_cnt     <= '0;
            sdram_addr  <= '0;
            sdram_wdata <= '0;
            sdram_wr    <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            q_last <= Q;
            if (tick) begin
                din_last <= din_s2;
                rec_last <= record;
                if (!record) begin
                    state      <= StIdle;
                    sdram_wr   <= 1'b0;
                    pend_valid <= 1'b0;
                end else if (!rec_last) begin
                    state       <= StHunt;
                    sdram_addr  <= '0;
                    sdram_wr    <= 1'b0;
                    cnt         <= '0;
                    shreg       <= '0;
                    prev_bit    <= 1'b0;
                    alt         <= '0;
                    leader_seen <= 1'b0;
                    bit_cnt     <= '0;
                    lead_cnt    <= '0;
                    pend_valid  <= 1'b0;
                end else if (meter_on) begin
                    if (din_rise && cnt_inc >= MinPerC) cnt <= '0;
                    else cnt <= cnt_inc;
                    if (bit_ok) begin
                        shreg    <= shreg_nx;
                        prev_bit <= bit_val;
                    end
                    // A write strobe always lasts one tick; the address advances as it falls.
                    if (sdram_wr) begin
                        sdram_wr   <= 1'b0;
                        sdram_addr <= sdram_addr + 25'd1;
                    end
                    if (state == StHunt) begin
                        if (!sdram_wr && pend_valid) begin
                            sdram_wr    <= 1'b1;
                            sdram_wdata <= pend_data;
                            pend_valid  <= 1'b0;
                        end
                        if (lost) begin
                            alt         <= '0;
                            leader_seen <= 1'b0;
                        end else if (bit_ok) begin
                            if (bit_val != prev_bit) begin
                                if (alt != 5'd16) alt <= alt + 5'd1;
                                if (alt >= 5'd15) leader_seen <= 1'b1;
                            end else begin
                                alt <= '0;
                            end
                            if (leader_seen && shreg_nx == 8'h3C) begin
                                state       <= (LEADER_BYTES == 0) ? StSyncb : StLead;
                                bit_cnt     <= '0;
                                lead_cnt    <= '0;
                                alt         <= '0;
                                leader_seen <= 1'b0;
                            end
                        end
                    end else if (lost) begin
                        state       <= StHunt;
                        bit_cnt     <= '0;
                        alt         <= '0;
                        leader_seen <= 1'b0;
                    end else begin
                        unique case (state)
                            StLead: begin
                                if (sdram_wr) begin
                                    lead_cnt <= lead_cnt + 8'd1;
                                    if (lead_cnt == LeadLastC) state <= StSyncb;
                                end else begin
                                    sdram_wr    <= 1'b1;
                                    sdram_wdata <= 8'h55;
                                end
                            end
                            StSyncb: begin
                                if (sdram_wr) begin
                                    state <= StData;
                                end else begin
                                    sdram_wr    <= 1'b1;
                                    sdram_wdata <= 8'h3C;
                                end
                            end
                            StData: begin
                                if (!sdram_wr && pend_valid) begin
                                    sdram_wr    <= 1'b1;
                                    sdram_wdata <= pend_data;
                                    pend_valid  <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                        if (bit_ok) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                pend_valid <= 1'b1;
                                pend_data  <= shreg_nx;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cassette_rec.sv
// Bench for cassette_rec: FSK stimulus in Q-tick units, expected SDRAM writes checked by a
// scoreboard monitor. Timing parameters are scaled down by ten to keep the run short.
module tb_cassette_rec;

    localparam int unsigned Thresh  = 56;
    localparam int unsigned MinPer  = 15;
    localparam int unsigned Timeout = 150;
    localparam int unsigned LeadN   = 2;
    localparam int          P1      = 25;
    localparam int          P0      = 70;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Q = 1'b0;
    logic        en = 1'b1;
    logic        record = 1'b0;
    logic        din = 1'b0;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_wdata;
    logic        sdram_wr;
    logic [2:0]  status;

    int   passed = 0;
    int   total = 0;
    int   tick_cnt = 0;
    int   t0 = 0;
    logic q_d = 1'b0;
    logic wr_d = 1'b0;
    bit   found = 1'b0;
    wr_t  exp_q[$];

    cassette_rec #(
        .THRESH(Thresh),
        .MIN_PER(MinPer),
        .TIMEOUT(Timeout),
        .LEADER_BYTES(LeadN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .Q(Q),
        .en(en),
        .record(record),
        .din(din),
        .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata),
        .sdram_wr(sdram_wr),
        .status(status)
    );

    always #5 clk = ~clk;
    always @(negedge clk) Q <= ~Q;

    // Independent count of qualified ticks, matching the DUT's view of Q and en.
    always @(posedge clk) begin
        q_d <= Q;
        if (Q && !q_d && en && reset_n) tick_cnt <= tick_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        wr_d <= sdram_wr;
        if (sdram_wr && !wr_d) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                         sdram_addr, sdram_wdata);
            end else begin
                check("wr_addr", {7'd0, sdram_addr}, {7'd0, exp_q[0].addr});
                check("wr_data", {24'd0, sdram_wdata}, {24'd0, exp_q[0].data});
                exp_q.delete(0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({25'(a), d});
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = tick_cnt + n;
        guard  = 0;
        while (tick_cnt < target) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL wait_ticks: tick budget expired");
                $fatal(1, "tick wait");
            end
        end
    endtask

    // One FSK cycle: rising edge now, next rising edge per ticks later.
    task automatic send_bit(input logic b, input int per, input bit glitch);
        din = 1'b1;
        if (glitch) begin
            wait_ticks(5);
            din = 1'b0;
            wait_ticks(5);
            din = 1'b1;
            wait_ticks(per / 2 - 10);
        end else begin
            wait_ticks(per / 2);
        end
        din = 1'b0;
        wait_ticks(per - per / 2);
        if (b !== 1'b0 && b !== 1'b1) $display("FAIL send_bit: bad bit value");
    endtask

    task automatic send_byte(input logic [7:0] v, input int p1, input int p0, input int gbit);
        for (int i = 0; i < 8; i++) send_bit(v[i], v[i] ? p1 : p0, i == gbit);
    endtask

    task automatic leader_3c();
        for (int i = 0; i < 3; i++) send_byte(8'h55, P1, P0, -1);
        send_byte(8'h3C, P1, P0, -1);
    endtask

    task automatic final_edge();
        din = 1'b1;
        wait_ticks(10);
        din = 1'b0;
        wait_ticks(10);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_addr", {7'd0, sdram_addr}, 32'd0);
        check("rst_wdata", {24'd0, sdram_wdata}, 32'd0);
        check("rst_wr", {31'd0, sdram_wr}, 32'd0);
        check("rst_status", {29'd0, status}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full block: leader, sync, data incl. threshold boundary and a glitched cycle.
        record = 1'b1;
        wait_ticks(3);
        check("hunt_entry", {29'd0, status}, 32'd1);
        push(0, 8'h55); push(1, 8'h55); push(2, 8'h3C); push(3, 8'h00);
        push(4, 8'hA5); push(5, 8'h0F); push(6, 8'h5A);
        leader_3c();
        send_byte(8'h00, P1, P0, -1);
        send_byte(8'hA5, P1, P0, -1);
        send_byte(8'h0F, int'(Thresh) - 1, int'(Thresh), -1);
        send_byte(8'h5A, P1, P0, 2);
        final_edge();
        wait_ticks(10);
        check("data_state", {29'd0, status}, 32'd4);
        wait_ticks(200);
        check("loss_to_hunt", {29'd0, status}, 32'd1);
        check("addr_after_block", {7'd0, sdram_addr}, 32'd7);

        // Sync byte without leader must not lock.
        send_byte(8'h3C, P1, P0, -1);
        final_edge();
        wait_ticks(10);
        check("no_lock_status", {29'd0, status}, 32'd1);
        wait_ticks(200);

        // Carrier lost after three data bits, then a fresh block.
        push(7, 8'h55); push(8, 8'h55); push(9, 8'h3C);
        leader_3c();
        send_bit(1'b1, P1, 1'b0);
        send_bit(1'b0, P0, 1'b0);
        send_bit(1'b1, P1, 1'b0);
        final_edge();
        wait_ticks(200);
        check("partial_loss_status", {29'd0, status}, 32'd1);
        check("partial_loss_addr", {7'd0, sdram_addr}, 32'd10);
        push(10, 8'h55); push(11, 8'h55); push(12, 8'h3C);
        leader_3c();
        final_edge();
        wait_ticks(10);
        check("relock_state", {29'd0, status}, 32'd4);
        wait_ticks(200);

        // Record dropped mid-byte, then raised again.
        push(13, 8'h55); push(14, 8'h55); push(15, 8'h3C);
        leader_3c();
        send_bit(1'b1, P1, 1'b0);
        send_bit(1'b1, P1, 1'b0);
        send_bit(1'b0, P0, 1'b0);
        send_bit(1'b0, P0, 1'b0);
        record = 1'b0;
        wait_ticks(3);
        check("rec_off_status", {29'd0, status}, 32'd0);
        check("rec_off_addr_hold", {7'd0, sdram_addr}, 32'd16);
        record = 1'b1;
        wait_ticks(3);
        check("rec_on_status", {29'd0, status}, 32'd1);
        check("rec_on_addr", {7'd0, sdram_addr}, 32'd0);
        push(0, 8'h55); push(1, 8'h55); push(2, 8'h3C); push(3, 8'hC3);
        leader_3c();
        send_byte(8'hC3, P1, P0, -1);
        din = 1'b1;
        found = 1'b0;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (sdram_wr) begin
                found = 1'b1;
                break;
            end
        end
        check("wr_before_reset", {31'd0, found}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst2_wr", {31'd0, sdram_wr}, 32'd0);
        check("rst2_addr", {7'd0, sdram_addr}, 32'd0);
        check("rst2_wdata", {24'd0, sdram_wdata}, 32'd0);
        check("rst2_status", {29'd0, status}, 32'd0);
        record = 1'b0;
        din = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // en held low for 1000 ticks in the middle of a data byte.
        record = 1'b1;
        wait_ticks(3);
        push(0, 8'h55); push(1, 8'h55); push(2, 8'h3C); push(3, 8'hA5); push(4, 8'h5A);
        t0 = tick_cnt;
        fork
            begin
                leader_3c();
                send_byte(8'hA5, P1, P0, -1);
                send_byte(8'h5A, P1, P0, -1);
                final_edge();
            end
            begin
                for (int g = 0; g < 10000 && tick_cnt < t0 + 1710; g++) @(negedge clk);
                en = 1'b0;
                repeat (2000) @(negedge clk);
                en = 1'b1;
            end
        join
        wait_ticks(10);
        check("en_gap_state", {29'd0, status}, 32'd4);

        for (int g = 0; g < 1000 && exp_q.size() != 0; g++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cassette_rec.md
# cassette_rec

Cassette recorder for the CoCo2 core: decodes the FSK bit stream on the cassette-in comparator (1200 Hz cycle = 0, 2400 Hz cycle = 1, LSB first) into bytes and writes them sequentially to SDRAM from address 0. It complements the cassette player. Every recorded block is stored as leader bytes, then 0x3C, then the data, so a recorded image replays through the player unchanged. All timing is measured in Q ticks (about 0.89 MHz).

## Interface
- THRESH, 559: period in Q ticks at or above which a cycle decodes as 0; below it decodes as 1.
- MIN_PER, 150: periods shorter than this are glitches and are ignored.
- TIMEOUT, 1500: period in Q ticks that signals carrier lost; the period counter saturates here.
- LEADER_BYTES, 2: number of 0x55 bytes written ahead of 0x3C on each lock.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- Q  in  1  CPU Q clock. A 0→1 transition, when `en`=1, is one "tick".
- en  in  1  tick qualifier; no state changes when it is low.
- record  in  1  record enable, level-sensitive, sampled on ticks.
- din  in  1  comparator output, asynchronous. It is synchronized with two clk flops before use.
- sdram_addr  out  25  write address.
- sdram_wdata  out  8  write byte.
- sdram_wr  out  1  write strobe, high for exactly one tick.
- status  out  3  current FSM state encoding.

## Operation
- State encoding: IDLE=0, HUNT=1, LEAD=2, SYNCB=3, DATA=4.
- Reset values: all outputs are 0, the state is IDLE, and all counters and registers are cleared.
- Record control:
  - A rising `record` seen on a tick sets sdram_addr=0 and enters HUNT.
  - `record`=0 on any tick forces IDLE and sdram_wr=0. Any pending byte is discarded and sdram_addr holds its value.
- Period meter (runs in every state except IDLE):
  - 11-bit counter, incremented each tick, saturating at TIMEOUT.
  - On a synchronized din rising edge:
    - count < MIN_PER: the edge is ignored and the counter keeps running.
    - count ≥ TIMEOUT: the counter restarts at 0 and no bit is emitted.
    - otherwise: emit bit = (count < THRESH), then restart the counter at 0.
- Bit shifter: shreg <= {bit, shreg[7:1]} on each emitted bit.
- HUNT:
  - alt counter increments when a bit differs from the previous bit and clears otherwise.
  - leader_seen is set when alt reaches 16.
  - Lock condition: leader_seen and shreg==8'h3C. On lock, enter LEAD and clear the bit counter.
- LEAD: writes LEADER_BYTES bytes of 0x55, then enters SYNCB.
- SYNCB: writes 0x3C, then enters DATA.
- DATA: each 8th bit latches shreg into the pending byte, which is then written. Bits keep accumulating during LEAD and SYNCB.
- Carrier loss: the counter reaching TIMEOUT in HUNT clears alt and leader_seen. In LEAD, SYNCB or DATA it returns the FSM to HUNT; the partial byte is dropped, but a byte already pending is still written.
- Write port: sdram_wr is high for one tick with addr and data stable. sdram_addr increments on the tick sdram_wr falls. The address wraps from 0x1FFFFFF to 0.
- Ticks with en=0 freeze every counter and register; sdram_wr holds its value.

## Timing
- din edge to bit decision: 2 clk of synchronization, then the next tick.
- Byte complete on tick T: sdram_wr=1 at T+1, sdram_wr=0 and addr+1 at T+2.
- Lock on tick T:
  - 0x55 writes at T+1, T+3, … (every other tick).
  - 0x3C at T+1+2·LEADER_BYTES.
  - DATA follows one tick after that.
- The minimum byte spacing (8×MIN_PER ticks) exceeds the write duration (2 ticks), so no overflow condition exists.
- reset_n asserted mid-write: sdram_wr drops immediately (asynchronous).

## Test plan
- 24 cycles of 2400/1200 Hz alternating leader (0x55), then byte 0x3C, then 0x00, 0xA5 → memory addresses 0..4 hold 55 55 3C 00 A5; status reaches 4.
- Period 558 ticks decodes as 1 and period 559 decodes as 0; a 100-tick pulse inserted mid-cycle leaves the byte value unchanged.
- 0x3C sent without a preceding leader → no lock, no sdram_wr; status stays 1.
- Carrier stops after 3 data bits → after 1500 ticks status=1 and no write occurs. A new leader plus 0x3C then writes 55 55 3C at the next addresses.
- Drop `record` mid-byte, then raise it again → the next lock writes from address 0. reset_n pulse low → all outputs 0 and status 0.
- en held low for 1000 ticks mid-byte → decoded bytes are identical to the run with en held high.
